// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings,
// saturating counter helpers and the BHT controller state type.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPD_WR
    } bht_state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved branches ({idx, taken}) until
// the BHT port is free. Flags are decoded from a registered occupancy count.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: one table port shared between IF lookups,
// the post-reset clear walk and queued read-modify-write counter updates.
module bht_ctrl #(
    parameter int IDX_W    = 6,
    parameter int PC_W     = 32,
    parameter int UQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lu_valid,
    input  logic [PC_W-1:0] lu_pc,
    output logic            lu_ready,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready,
    output logic            busy_init
);

    import bp_pkg::*;

    localparam int ENTRIES = 1 << IDX_W;

    bht_state_t       state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]       bht_q [ENTRIES];

    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [1:0]       rd_q;
    logic [IDX_W-1:0] hold_idx_q;
    logic             hold_taken_q;

    logic [IDX_W-1:0] lu_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [IDX_W:0]   uq_dout;
    logic             uq_full;
    logic             uq_empty;
    logic             uq_push;

    logic             lu_acc;
    logic             pop;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [1:0]       wdata;

    logic             unused_pc_bits;

    assign lu_idx         = lu_pc[IDX_W+1:2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{lu_pc[PC_W-1:IDX_W+2], lu_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign uq_push    = upd_valid && upd_ready;
    assign head_idx   = uq_dout[IDX_W:1];
    assign head_taken = uq_dout[0];

    bp_upd_fifo #(
        .DEPTH (UQ_DEPTH),
        .W     (IDX_W + 1)
    ) u_upd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (uq_push),
        .din_i   ({upd_idx, upd_taken}),
        .pop_i   (pop),
        .dout_o  (uq_dout),
        .full_o  (uq_full),
        .empty_o (uq_empty)
    );

    // Port arbitration: a full queue is drained first, then lookups, then idle drains
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        lu_ready   = 1'b0;
        lu_acc     = 1'b0;
        pop        = 1'b0;
        we         = 1'b0;
        waddr      = init_cnt_q;
        wdata      = CNT_SNT;
        case (state_q)
            INIT: begin
                we         = 1'b1;
                waddr      = init_cnt_q;
                wdata      = CNT_SNT;
                init_cnt_d = init_cnt_q + 1'b1;
                if (&init_cnt_q) state_d = IDLE;
            end
            IDLE: begin
                if (uq_full) begin
                    pop     = 1'b1;
                    state_d = UPD_WR;
                end else if (lu_valid) begin
                    lu_ready = 1'b1;
                    lu_acc   = 1'b1;
                end else if (!uq_empty) begin
                    pop     = 1'b1;
                    state_d = UPD_WR;
                end else begin
                    lu_ready = 1'b1;
                end
            end
            UPD_WR: begin
                we      = 1'b1;
                waddr   = hold_idx_q;
                wdata   = hold_taken_q ? sat_inc(rd_q) : sat_dec(rd_q);
                state_d = IDLE;
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Control state: FSM, clear-walk index and the prediction pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            pred_valid_q <= lu_acc;
            if (lu_acc) pred_taken_q <= bht_q[lu_idx][1];
        end
    end

    // Read half of the RMW: capture the popped entry and its current counter
    always_ff @(posedge clk) begin
        if (pop) begin
            rd_q         <= bht_q[head_idx];
            hold_idx_q   <= head_idx;
            hold_taken_q <= head_taken;
        end
    end

    // Single write port into the counter table
    always_ff @(posedge clk) begin
        if (we) bht_q[waddr] <= wdata;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign upd_ready  = !uq_full;
    assign busy_init  = (state_q == INIT);

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed self-checking bench for bht_ctrl: table-driven counter updates
// plus hand-written sequences for queue pressure, stale lookups and reset.
module tb_bht_ctrl;

    localparam int IDX_W    = 6;
    localparam int PC_W     = 32;
    localparam int UQ_DEPTH = 4;
    localparam int ENTRIES  = 1 << IDX_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            lu_valid = 1'b0;
    logic [PC_W-1:0] lu_pc = '0;
    logic            lu_ready;
    logic            pred_valid;
    logic            pred_taken;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic            upd_ready;
    logic            busy_init;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [1:0]  exp_cnt;
        logic        exp_pred;
    } vec_t;

    vec_t vecs[13];

    bht_ctrl #(
        .IDX_W    (IDX_W),
        .PC_W     (PC_W),
        .UQ_DEPTH (UQ_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lu_valid   (lu_valid),
        .lu_pc      (lu_pc),
        .lu_ready   (lu_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .busy_init  (busy_init)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(ENTRIES - 1));
    endfunction

    // Call right after rst has been released at posedge+1
    task automatic wait_init(input string name);
        int n = 0;
        while (busy_init === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_len"}, n, 64);
        chk({name, "_lu_ready"}, lu_ready, 1);
    endtask

    task automatic scan_zero(input string name);
        int nz = 0;
        for (int k = 0; k < ENTRIES; k++)
            if (dut.bht_q[k] !== 2'b00) nz++;
        chk(name, nz, 0);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp, input string name);
        lu_valid = 1'b1;
        lu_pc    = pc;
        #1;
        chk({name, "_ready"}, lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        chk({name, "_pv"}, pred_valid, 1);
        chk({name, "_pt"}, pred_taken, exp);
        tick();
        chk({name, "_pv_off"}, pred_valid, 0);
    endtask

    // Enqueue one resolution and let the idle controller drain it (pop, write)
    task automatic update(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
        tick();
        tick();
    endtask

    logic [31:0] b2b_pc[4];
    logic        b2b_tk[4];

    initial begin
        vecs[0]  = '{32'h0000_0040, 1'b1, 2'b01, 1'b0};
        vecs[1]  = '{32'h0000_0040, 1'b1, 2'b10, 1'b1};
        vecs[2]  = '{32'h0000_0040, 1'b1, 2'b11, 1'b1};
        vecs[3]  = '{32'h0000_0040, 1'b1, 2'b11, 1'b1};
        vecs[4]  = '{32'h0000_0040, 1'b0, 2'b10, 1'b1};
        vecs[5]  = '{32'h0000_0040, 1'b0, 2'b01, 1'b0};
        vecs[6]  = '{32'h0000_0040, 1'b0, 2'b00, 1'b0};
        vecs[7]  = '{32'h0000_0040, 1'b0, 2'b00, 1'b0};
        vecs[8]  = '{32'h0000_0044, 1'b1, 2'b01, 1'b0};
        vecs[9]  = '{32'h1000_0048, 1'b1, 2'b01, 1'b0};
        vecs[10] = '{32'h1000_0048, 1'b1, 2'b10, 1'b1};
        vecs[11] = '{32'h0000_0100, 1'b1, 2'b01, 1'b0};
        vecs[12] = '{32'h0000_0040, 1'b1, 2'b01, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy_init, 1);
        chk("rst_lu_ready", lu_ready, 0);
        chk("rst_pv", pred_valid, 0);
        chk("rst_pt", pred_taken, 0);
        chk("rst_upd_ready", upd_ready, 1);
        rst = 1'b0;
        wait_init("init1");

        lookup(32'h0000_0100, 1'b0, "first_lu");

        // Counter update vectors
        for (int i = 0; i < 13; i++) begin
            update(vecs[i].pc, vecs[i].taken);
            chk($sformatf("vec%0d_cnt", i), dut.bht_q[pc_idx(vecs[i].pc)], vecs[i].exp_cnt);
            lookup(vecs[i].pc, vecs[i].exp_pred, $sformatf("vec%0d_lu", i));
        end

        // Stale lookup while an update to idx 16 is queued (counter 01 -> 10)
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_0040;
        upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        lu_valid  = 1'b1;
        lu_pc     = 32'h0000_0040;
        #1;
        chk("stale_ready", lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        chk("stale_pv", pred_valid, 1);
        chk("stale_pt", pred_taken, 0);
        tick();
        tick();
        chk("fresh_cnt", dut.bht_q[16], 2'b10);
        lookup(32'h0000_0040, 1'b1, "fresh_lu");

        // Continuous lookups with four back-to-back updates
        b2b_pc[0] = 32'h0000_004C; b2b_tk[0] = 1'b0;
        b2b_pc[1] = 32'h0000_0050; b2b_tk[1] = 1'b1;
        b2b_pc[2] = 32'h0000_004C; b2b_tk[2] = 1'b1;
        b2b_pc[3] = 32'h0000_0054; b2b_tk[3] = 1'b1;
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_pc    = b2b_pc[i];
            upd_taken = b2b_tk[i];
            #1;
            chk($sformatf("b2b_lu_ready%0d", i), lu_ready, 1);
            chk($sformatf("b2b_upd_ready%0d", i), upd_ready, 1);
            tick();
        end
        upd_valid = 1'b0;
        #1;
        chk("b2b_full_upd_ready", upd_ready, 0);
        chk("b2b_stall0", lu_ready, 0);
        chk("b2b_pv_c4", pred_valid, 1);
        tick();
        chk("b2b_stall1", lu_ready, 0);
        chk("b2b_upd_ready_after", upd_ready, 1);
        chk("b2b_pv_c5", pred_valid, 0);
        tick();
        chk("b2b_resume", lu_ready, 1);
        chk("b2b_pv_c6", pred_valid, 0);
        tick();
        chk("b2b_pv_c7", pred_valid, 1);
        lu_valid = 1'b0;
        repeat (8) tick();
        chk("b2b_idx19", dut.bht_q[19], 2'b01);
        chk("b2b_idx20", dut.bht_q[20], 2'b01);
        chk("b2b_idx21", dut.bht_q[21], 2'b01);

        // Reset drops a pending prediction and clears the table
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_0040;
        tick();
        lu_valid = 1'b0;
        chk("pre_rst_pv", pred_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst2_pv", pred_valid, 0);
        chk("rst2_busy", busy_init, 1);
        tick();
        rst = 1'b0;
        wait_init("init2");
        scan_zero("init2_clear");

        // Reset during UPD_WR with three entries still queued
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h0000_00A0 + 32'(4 * i);
            upd_taken = 1'b1;
            tick();
        end
        upd_valid = 1'b0;
        tick();
        lu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst3_upd_ready", upd_ready, 1);
        chk("rst3_pv", pred_valid, 0);
        chk("rst3_lu_ready", lu_ready, 0);
        chk("rst3_busy", busy_init, 1);
        tick();
        rst = 1'b0;
        wait_init("init3");
        repeat (10) tick();
        scan_zero("init3_clear");
        lookup(32'h0000_00A0, 1'b0, "post_rst_lu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
